// File: rtl/pool_window_buffer_if.sv
// Purpose: pixel-stream in / 2x2-window out bundle for the pool window former.
// Latency: n/a (signal bundle only).
// Backpressure: none; the producer never stalls, every valid pixel is consumed.
interface pool_window_buffer_if #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
);
    localparam int WCW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
    localparam int WRW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;

    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_sof;
    logic [DATA_W-1:0] pixel1;
    logic [DATA_W-1:0] pixel2;
    logic [DATA_W-1:0] pixel3;
    logic [DATA_W-1:0] pixel4;
    logic              win_valid;
    logic [WCW-1:0]    win_col;
    logic [WRW-1:0]    win_row;
    logic              frame_done;

    // Pixel producer side (drives the stream, observes windows).
    modport master (
        output pix_in, pix_valid, pix_sof,
        input  pixel1, pixel2, pixel3, pixel4,
        input  win_valid, win_col, win_row, frame_done
    );

    // Window former side.
    modport slave (
        input  pix_in, pix_valid, pix_sof,
        output pixel1, pixel2, pixel3, pixel4,
        output win_valid, win_col, win_row, frame_done
    );
endinterface

// File: rtl/pool_window_buffer.sv
// Purpose: forms non-overlapping 2x2 windows (stride 2) from a raster pixel stream using one row buffer.
// Latency: 1 cycle from acceptance of the bottom-right pixel to win_valid.
// Backpressure: none; pix_valid=0 simply freezes counters, buffer and registers.
module pool_window_buffer #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pool_window_buffer_if.slave   bus
);
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WCW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
    localparam int WRW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Position counters: column/row of the next pixel to arrive.
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;

    // Previous even row, and the two current-row helpers.
    logic [DATA_W-1:0] r_linebuf [IMG_W];
    logic [DATA_W-1:0] r_prev;       // pixel at col-1 of the current row
    logic [DATA_W-1:0] r_top_left;   // linebuf[col-1] captured before it is overwritten

    // Registered window outputs.
    logic [DATA_W-1:0] r_p1, r_p2, r_p3, r_p4;
    logic [WCW-1:0]    r_win_col;
    logic [WRW-1:0]    r_win_row;
    logic              r_win_valid;
    logic              r_frame_done;

    // Effective position of the incoming pixel: sof forces (0,0).
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic [DATA_W-1:0] w_lb_rd;
    logic              w_emit;
    logic              w_last;

    assign w_col   = bus.pix_sof ? '0 : r_col;
    assign w_row   = bus.pix_sof ? '0 : r_row;
    assign w_lb_rd = r_linebuf[w_col];
    assign w_emit  = bus.pix_valid && w_col[0] && w_row[0];
    assign w_last  = (w_col == COL_LAST) && (w_row == ROW_LAST);

    // Advance the raster position on every accepted pixel, wrapping at row and frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.pix_valid) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Row buffer: no reset, every location is written in row 0 before row 1 reads it.
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            r_linebuf[w_col] <= bus.pix_in;
        end
    end

    // Current-row history. Odd-row writes overwrite the buffer one pixel ahead of the
    // window read, so the top-left value is snapshotted at the even column instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_top_left <= '0;
        end else if (bus.pix_valid) begin
            r_prev <= bus.pix_in;
            if (!w_col[0]) begin
                r_top_left <= w_lb_rd;
            end
        end
    end

    // Window capture: pixel/coordinate outputs hold between windows, strobes pulse once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1         <= '0;
            r_p2         <= '0;
            r_p3         <= '0;
            r_p4         <= '0;
            r_win_col    <= '0;
            r_win_row    <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_emit;
            r_frame_done <= w_emit && w_last;
            if (w_emit) begin
                r_p1      <= r_top_left;
                r_p2      <= w_lb_rd;
                r_p3      <= r_prev;
                r_p4      <= bus.pix_in;
                r_win_col <= WCW'(w_col >> 1);
                r_win_row <= WRW'(w_row >> 1);
            end
        end
    end

    assign bus.pixel1     = r_p1;
    assign bus.pixel2     = r_p2;
    assign bus.pixel3     = r_p3;
    assign bus.pixel4     = r_p4;
    assign bus.win_col    = r_win_col;
    assign bus.win_row    = r_win_row;
    assign bus.win_valid  = r_win_valid;
    assign bus.frame_done = r_frame_done;
endmodule
